// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply/divide unit for the execute stage.
// Reads the two register-file operands, runs an unsigned shift-add multiply
// or a restoring divide one bit per clock, then issues a single write-back
// request (result, destination, write enable) to the register file.
//
// Optional feature macro: MULDIV_DIV_EN
//   defined   : DIVU/REMU use the restoring divider (N iterations).
//   undefined : divider datapath is left out; DIVU/REMU complete one cycle
//               after acceptance with result 0 and no register write.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; done/we_out/result held at zero
// CALC   | one multiply or divide iteration per clock, N in total
// DONE   | one-cycle completion pulse; write-back request presented
module muldiv_iter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         flush,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [4:0]   rd_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [4:0]   rd_out,
  output logic         we_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  // Iteration index of the final step; the counter runs 0..N-1.
  localparam logic [5:0] LAST_ITER = 6'(N - 1);

  state_t         state;
  logic [1:0]     op_q;
  logic [N-1:0]   opa;
  logic [N-1:0]   opb;
  logic [2*N-1:0] acc;
  logic [5:0]     cnt;

  logic [2*N-1:0] mul_addend;
  logic [2*N-1:0] mul_acc_nxt;
  logic [N-1:0]   calc_result;
  logic           div_bypass;

`ifdef MULDIV_DIV_EN
  // Partial remainder is always below the divisor, so N bits hold it;
  // the trial subtract works on the N+1-bit shifted remainder.
  logic [N-1:0]   rem;
  logic [N:0]     div_shift;
  logic           div_ge;
  logic [N-1:0]   div_diff;
  logic [N-1:0]   div_rem_nxt;
  logic [N-1:0]   div_q_nxt;

  assign div_bypass = 1'b0;
`else
  // No divider: divide ops skip CALC and finish with a zero, non-writing result.
  assign div_bypass = op[1];
`endif

  // Shift-add multiply step: multiplier bits are consumed MSB first, so the
  // product is doubled before the partial product is added.
  always_comb begin
    mul_addend  = opb[N-1] ? {{N{1'b0}}, opa} : '0;
    mul_acc_nxt = (acc << 1) + mul_addend;
  end

`ifdef MULDIV_DIV_EN
  // Restoring divide step: bring down the next dividend bit, trial subtract,
  // keep the difference only if it did not go negative. A zero divisor makes
  // every trial succeed, which yields all-ones quotient and remainder = a
  // without any special-case logic.
  always_comb begin
    div_shift   = {rem, opa[N-1]};
    div_ge      = (div_shift >= {1'b0, opb});
    div_diff    = div_shift[N-1:0] - opb;
    div_rem_nxt = div_ge ? div_diff : div_shift[N-1:0];
    div_q_nxt   = {acc[N-2:0], div_ge};
  end
`endif

  // Select the value the final iteration produces for the requested op.
  always_comb begin
    calc_result = '0;
    case (op_q)
      OP_MUL:   calc_result = mul_acc_nxt[N-1:0];
      OP_MULHU: calc_result = mul_acc_nxt[2*N-1:N];
`ifdef MULDIV_DIV_EN
      OP_DIVU:  calc_result = div_q_nxt;
      OP_REMU:  calc_result = div_rem_nxt;
`endif
      default:  calc_result = '0;
    endcase
  end

  // Control FSM, datapath registers and registered write-back outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= OP_MUL;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
`ifdef MULDIV_DIV_EN
      rem    <= '0;
`endif
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
      we_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done   <= 1'b0;
          we_out <= 1'b0;
          result <= '0;
          // flush beats start: nothing is captured when both are high.
          if (start && !flush) begin
            op_q   <= op;
            opa    <= a;
            opb    <= b;
            rd_out <= rd_in;
            acc    <= '0;
            cnt    <= '0;
`ifdef MULDIV_DIV_EN
            rem    <= '0;
`endif
            busy   <= 1'b1;
            if (div_bypass) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 6'd1;
`ifdef MULDIV_DIV_EN
            if (op_q[1]) begin
              acc <= {{N{1'b0}}, div_q_nxt};
              rem <= div_rem_nxt;
              opa <= opa << 1;
            end else begin
              acc <= mul_acc_nxt;
              opb <= opb << 1;
            end
`else
            acc <= mul_acc_nxt;
            opb <= opb << 1;
`endif
            if (cnt == LAST_ITER) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= calc_result;
              we_out <= (rd_out != 5'd0);
            end
          end
        end

        S_DONE: begin
          // Leave after exactly one cycle whether or not flush is present.
          state  <= S_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          we_out <= 1'b0;
          result <= '0;
        end

        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          we_out <= 1'b0;
          result <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative multiply/divide unit for the execute stage of the processor core. Consumes the two register-file read operands (RD1/RD2), runs a shift-add multiply or restoring divide over N cycles, and drives a write-back request (data, 5-bit destination address, write enable) that connects directly to the register file's WD/address/WE inputs. Provides a start/busy/done handshake so the control unit can stall issue while an operation is in flight.

## Interface
- N, 32, operand/result width in bits (≥ 2).
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- start  input  1  request; accepted only in IDLE.
- flush  input  1  synchronous abort of the in-flight operation.
- op  input  2  00 MUL (low N bits), 01 MULHU (high N bits, unsigned), 10 DIVU, 11 REMU.
- a  input  N  operand A / dividend (from RD1).
- b  input  N  operand B / divisor (from RD2).
- rd_in  input  5  destination register address.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle completion pulse.
- result  output  N  result; valid only while done=1, else 0.
- rd_out  output  5  captured destination address.
- we_out  output  1  register-file write enable; equals done & (rd_out != 0).

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- IDLE: start=1 and flush=0 at edge → capture a, b, op, rd_in; clear 2N-bit accumulator and 6-bit iteration counter; go to CALC.
- CALC: one iteration per edge; counter increments; on the edge completing iteration N-1 → DONE.
- MUL/MULHU: unsigned shift-add into 2N-bit product; MUL returns product[N-1:0], MULHU product[2N-1:N]. Overflow is discarded; no sign handling.
- DIVU/REMU: restoring division, one quotient bit per iteration, MSB first; N+1-bit partial remainder for the trial subtract.
- Divide by zero: no special path needed in the datapath; result forced to all-ones (DIVU) or a (REMU); same latency.
- DONE: done=1, result and rd_out driven, we_out per rule above; next edge → IDLE unconditionally.
- start in CALC or DONE: ignored, no queuing; caller must wait for busy=0.
- flush in CALC or DONE: next edge → IDLE; no done pulse is produced (if flush arrives during DONE, that cycle's done/we_out still stand; flush only prevents future pulses). flush and start together in IDLE: flush wins, nothing captured.
- Writes to register 0 are suppressed by we_out masking; done still pulses.

## Timing
- Reset values: busy=0, done=0, we_out=0, result=0, rd_out=0; state IDLE.
- Start accepted at edge k → busy=1 from k; done=1 in cycle after edge k+N; busy falls after edge k+N+1.
- Latency start-to-done: N+1 cycles (33 at N=32); throughput one op per N+2 cycles.
- Outputs are registered; no combinational path from inputs to outputs.
- reset asserted mid-operation: immediate return to IDLE, outputs zero, operation lost, no done.

## Configuration
- MULDIV_DIV_EN defined: DIVU/REMU implemented as above.
- Not defined: divider datapath omitted. DIVU/REMU accepted, go IDLE→DONE in one cycle (done in cycle after the start edge) with result=0 and we_out=0; MUL/MULHU unchanged.

## Test plan
- MUL a=7, b=6, rd_in=5 → done and we_out high exactly 33 cycles after start, result=42, rd_out=5.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF → result=0xFFFFFFFE; MUL same operands → 0x00000001.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5 (with MULDIV_DIV_EN); without macro DIVU 100/7 → done after 1 cycle, result=0, we_out=0.
- start pulsed again at cycle 10 of a MUL → ignored; single done at cycle 33 with first op's result; rd_in=0 → done=1, we_out=0.
- flush at cycle 15 of DIVU → busy=0 after next edge, no done; start with flush in IDLE → not accepted.
- reset asserted at cycle 20 of MUL → all outputs 0 immediately; after release, a new MUL 3*3 → 9 with normal 33-cycle latency.
